iob_regfile_scan_reader: RTL and testbench
==========================================

// Module: iob_regfile_scan_reader
// PURPOSE
//  Single-clock read-side sequencer for an iob register-file read port (r_en/r_addr/r_data, fixed latency).
//  On a start command it reads COUNT consecutive addresses, with wrap-around.
//  Returned words go out as a valid/ready stream with a last flag.
//  Credit-based issue: read data is never lost, however long ready_i is held low.
// PARAMETERS
//  ADDR_W     4   regfile address width; 2**ADDR_W entries
//  DATA_W     32  regfile word width
//  RD_LAT     2   cycles from r_en_o/r_addr_o sampled to r_data_i valid (>=1)
//  BUF_DEPTH  4   output buffer entries (>=1); full throughput needs >= RD_LAT+2
// PORTS
//  clk_i          in   1         clock, rising edge
//  arst_n_i       in   1         reset; asynchronous, active-low
//  start_i        in   1         1-cycle start pulse; ignored while busy_o=1
//  start_addr_i   in   ADDR_W    first address, sampled with start_i
//  count_i        in   ADDR_W+1  words to read, 0..2**ADDR_W; sampled with start_i
//  abort_i        in   1         synchronous abort of the current scan
//  r_en_o         out  1         regfile read enable
//  r_addr_o       out  ADDR_W    regfile read address
//  r_data_i       in   DATA_W    regfile read data, RD_LAT cycles after r_en_o
//  data_o         out  DATA_W    stream data
//  valid_o        out  1         stream valid
//  ready_i        in   1         stream ready; transfer when valid_o & ready_i
//  last_o         out  1         set with the final word of a scan
//  busy_o         out  1         scan in progress, until its last word transfers
//  done_o         out  1         1-cycle pulse in the cycle after the last word transfers
// BEHAVIOUR
//  Reset (async on arst_n_i=0): all outputs 0; FSM=IDLE; buffer empty; in-flight tracker cleared.
//  FSM:
//   IDLE: start_i & count_i!=0 -> ISSUE; latch addr/count; busy_o=1.
//         start_i & count_i==0 -> no-op; done_o pulses next cycle; busy_o stays 0.
//   ISSUE: drives r_en_o=1, r_addr_o=addr when inflight+occupancy < BUF_DEPTH.
//          Each issue increments addr mod 2**ADDR_W (wraps 2**ADDR_W-1 -> 0) and decrements remaining.
//          Remaining reaching 0 -> DRAIN.
//   DRAIN: no issue; when the last_o word transfers -> IDLE; done_o=1 next cycle; busy_o=0 next cycle.
//  Outputs r_en_o and r_addr_o are registered. r_addr_o holds its value when r_en_o=0.
//  In-flight tracking: RD_LAT-deep valid shift register.
//   - Entry at the head captures r_data_i into the buffer tail.
//   - Each entry carries a last tag, set on the final issue.
//  Buffer: FIFO, first word presented at head.
//   - data_o/last_o/valid_o come straight from the buffer head registers.
//   - Push and pop in the same cycle are allowed, even when the buffer is full.
//  Credit rule: occupancy + inflight never exceeds BUF_DEPTH, so overflow cannot occur.
//   - The bench asserts this as an invariant.
//  Latency: start_i in cycle t, ready_i=1 -> r_en_o first high at t+1; valid_o first high at t+RD_LAT+2.
//   - With BUF_DEPTH >= RD_LAT+2, one word per cycle thereafter.
//  count_i=2**ADDR_W reads every entry exactly once, starting at start_addr_i.
//  abort_i (any state, priority over start_i):
//   - Next cycle: FSM=IDLE, buffer empty, in-flight valid bits cleared; valid_o, r_en_o, busy_o = 0.
//   - Returning data is discarded; done_o is not pulsed.
//   - A start_i in the cycle after abort is accepted.
//  Data ordering equals address issue order. Stalls (ready_i=0) never drop or duplicate words.
// STRUCTURE
//  Shared package iob_regfile_scan_pkg: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2).
//  Also in the package: the credit-width function clog2(BUF_DEPTH+1).
//  One sub-module: iob_regfile_scan_buf, a synchronous FIFO of {last,data}.
//   - FWFT, with registered head.
//   - Ports: push/pop/full/empty/level.
//  Top level: FSM, address/count counters, in-flight shift register, credit compare.
// TESTING (regfile model: entry k = 32'hA000_0000+k, RD_LAT=2, BUF_DEPTH=4, ADDR_W=4)
//  1 start_addr=3,count=5,ready=1 -> r_en_o at t+1..t+5; words A..03..A..07 on t+4..t+8, last with 07.
//     done_o at t+9.
//  2 start_addr=14,count=4 -> words 0E,0F,00,01 (wrap); count=16 from 0 -> all 16 entries once, in order.
//  3 count=8, ready toggled 1,0,0,1 repeating -> all 8 words in order, none lost or duplicated.
//     r_en_o stalls when occupancy+inflight=4.
//  4 count=6, abort_i after the 2nd transfer -> next cycle valid_o=0, busy_o=0, no done_o.
//     Immediate restart at addr 9 count 2 -> exactly 09,0A.
//  5 count=0 -> no r_en_o, done_o pulse at t+1; start_i while busy -> ignored, scan unchanged.
//  6 arst_n_i low mid-scan (buffer partly full) -> all outputs 0 asynchronously.
//     After release, a new scan is correct.

Source files
------------

// File: rtl/iob_regfile_scan_pkg.sv
// Shared definitions for the iob register-file scan reader.
//  - scan_state_e : FSM state encoding used by the top level.
//  - clog2        : ceiling log2, used to size the credit and level counters.
package iob_regfile_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Ceiling log2. Callers pass BUF_DEPTH+1, so the result is always >= 1.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/iob_regfile_scan_reader_if.sv
// Bus bundle for the scan reader: the register-file read port and the
// outgoing valid/ready stream.
//  master modport : the scan reader (drives r_en_o/r_addr_o and the stream).
//  slave modport  : the environment (regfile data return and stream sink).
// Signals:
//  r_en_o, r_addr_o : regfile read request
//  r_data_i         : regfile read data, fixed latency after the request
//  data_o, valid_o, last_o, ready_i : output stream
interface iob_regfile_scan_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);

    logic              r_en_o;
    logic [ADDR_W-1:0] r_addr_o;
    logic [DATA_W-1:0] r_data_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;

    modport master (
        output r_en_o, r_addr_o, data_o, valid_o, last_o,
        input  r_data_i, ready_i
    );

    modport slave (
        input  r_en_o, r_addr_o, data_o, valid_o, last_o,
        output r_data_i, ready_i
    );

endinterface

// File: rtl/iob_regfile_scan_buf.sv
// Output buffer of the scan reader: synchronous first-word-fall-through FIFO.
// Entry 0 is the head and is a plain register, so dout_o comes straight from
// flops. Pop shifts the entries down by one; push writes at the first free
// slot after the pop. Push and pop may coincide, even when full.
// Ports:
//  clk_i, arst_n_i : clock, asynchronous active-low reset
//  flush_i         : synchronous clear, priority over push/pop
//  push_i, din_i   : write request and word
//  pop_i           : read request (ignored when empty)
//  dout_o          : head word
//  full_o, empty_o : status
//  level_o         : number of stored words
module iob_regfile_scan_buf
    import iob_regfile_scan_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    parameter int LVL_W = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] ent_r   [DEPTH];
    logic [WIDTH-1:0] ent_nxt_s [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] vld_nxt_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic [LVL_W-1:0] wr_idx_s;
    logic             pop_s;
    logic             push_s;

    // Next-state of the entry shift array: shift on pop, then place the push.
    always_comb begin
        pop_s  = pop_i & vld_r[0];
        push_s = push_i & ((level_r != LVL_W'(DEPTH)) | pop_s);
        wr_idx_s = level_r - LVL_W'(pop_s);
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt_s[i] = ent_r[i];
        end
        vld_nxt_s = vld_r;
        if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_nxt_s[i] = ent_r[i+1];
                vld_nxt_s[i] = vld_r[i+1];
            end
            vld_nxt_s[DEPTH-1] = 1'b0;
        end else begin
            vld_nxt_s = vld_r;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_idx_s == LVL_W'(i))) begin
                ent_nxt_s[i] = din_i;
                vld_nxt_s[i] = 1'b1;
            end else begin
                vld_nxt_s[i] = vld_nxt_s[i];
            end
        end
        level_nxt_s = level_r + LVL_W'(push_s) - LVL_W'(pop_s);
    end

    // Entry, valid and level registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= {WIDTH{1'b0}};
            end
            vld_r   <= {DEPTH{1'b0}};
            level_r <= LVL_W'(1'b0);
        end else if (flush_i) begin
            vld_r   <= {DEPTH{1'b0}};
            level_r <= LVL_W'(1'b0);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= ent_nxt_s[i];
            end
            vld_r   <= vld_nxt_s;
            level_r <= level_nxt_s;
        end
    end

    assign dout_o  = ent_r[0];
    assign empty_o = ~vld_r[0];
    assign full_o  = (level_r == LVL_W'(DEPTH));
    assign level_o = level_r;

endmodule

// File: rtl/iob_regfile_scan_reader.sv
// Read-side sequencer for an iob register-file read port with fixed latency.
// A start command reads count_i consecutive addresses (wrapping at the top of
// the regfile) and streams the words out with a last flag on the final one.
// Issue is credit based: a read is only launched when the output buffer is
// guaranteed to have room for its data, so a stalled sink never loses words.
// Ports:
//  clk_i, arst_n_i : clock, asynchronous active-low reset
//  start_i         : start pulse, ignored while busy_o
//  start_addr_i    : first address of the scan
//  count_i         : words to read, 0..2**ADDR_W
//  abort_i         : synchronous abort, priority over start_i
//  busy_o          : scan in progress until its last word transfers
//  done_o          : one-cycle pulse after the last transfer (or a count 0 start)
//  bus             : regfile read port and output stream (master side)
module iob_regfile_scan_reader
    import iob_regfile_scan_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic                        start_i,
    input  logic [ADDR_W-1:0]           start_addr_i,
    input  logic [ADDR_W:0]             count_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        done_o,
    iob_regfile_scan_reader_if.master   bus
);

    localparam int CRED_W = clog2(BUF_DEPTH + 1);
    localparam int SUM_W  = CRED_W + 1;

    scan_state_e       state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s, cur_addr_s;
    logic [ADDR_W:0]   rem_r, rem_nxt_s, cur_rem_s;
    logic              r_en_r, r_last_r;
    logic [ADDR_W-1:0] r_addr_r;
    logic [RD_LAT-1:0] sr_vld_r, sr_vld_nxt_s;
    logic [RD_LAT-1:0] sr_last_r, sr_last_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              issue_s, issue_last_s;
    logic              credit_ok_s;
    logic [SUM_W-1:0]  inflight_s, used_s;
    logic              pop_s, push_s;
    logic [DATA_W:0]   head_s;
    logic              empty_s, full_s;
    logic [CRED_W-1:0] level_s;

    assign cur_addr_s = (state_r == IDLE) ? start_addr_i : addr_r;
    assign cur_rem_s  = (state_r == IDLE) ? count_i : rem_r;
    assign pop_s      = ~empty_s & bus.ready_i;
    assign push_s     = sr_vld_r[RD_LAT-1] & ~abort_i;

    // Credit check: the words held next cycle would be the buffer level plus
    // everything in flight (including this cycle's request) minus this pop.
    // A new request is allowed only while that total stays below BUF_DEPTH.
    always_comb begin
        inflight_s = SUM_W'(1'b0);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + SUM_W'(sr_vld_r[i]);
        end
        used_s = SUM_W'(level_s) + SUM_W'(r_en_r) + inflight_s - SUM_W'(pop_s);
        // A full buffer that is not draining this cycle can never take a word.
        credit_ok_s = (used_s < SUM_W'(BUF_DEPTH)) && !(full_s && !pop_s);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state, issue decision and counter updates.
    always_comb begin
        state_nxt_s  = state_r;
        addr_nxt_s   = addr_r;
        rem_nxt_s    = rem_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        if (abort_i) begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i && (count_i != (ADDR_W+1)'(1'b0))) begin
                        state_nxt_s = ISSUE;
                        busy_nxt_s  = 1'b1;
                        addr_nxt_s  = start_addr_i;
                        rem_nxt_s   = count_i;
                        issue_s     = credit_ok_s;
                    end else if (start_i) begin
                        // Empty scan: nothing to read, just acknowledge.
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ISSUE: begin
                    issue_s = credit_ok_s;
                end
                DRAIN: begin
                    if (pop_s && head_s[DATA_W]) begin
                        state_nxt_s = IDLE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end
            endcase
            if (issue_s) begin
                // Address counter wraps naturally at 2**ADDR_W.
                addr_nxt_s = cur_addr_s + ADDR_W'(1'b1);
                rem_nxt_s  = cur_rem_s - (ADDR_W+1)'(1'b1);
                if (cur_rem_s == (ADDR_W+1)'(1'b1)) begin
                    issue_last_s = 1'b1;
                    state_nxt_s  = DRAIN;
                end else begin
                    state_nxt_s  = ISSUE;
                end
            end else begin
                issue_last_s = 1'b0;
            end
        end
    end

    // In-flight tracker: one valid/last bit per cycle of read latency.
    always_comb begin
        sr_vld_nxt_s[0]  = r_en_r;
        sr_last_nxt_s[0] = r_last_r;
        for (int i = 1; i < RD_LAT; i++) begin
            sr_vld_nxt_s[i]  = sr_vld_r[i-1];
            sr_last_nxt_s[i] = sr_last_r[i-1];
        end
    end

    // Datapath registers: counters, read request outputs, tracker, status.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            addr_r    <= ADDR_W'(1'b0);
            rem_r     <= (ADDR_W+1)'(1'b0);
            r_en_r    <= 1'b0;
            r_last_r  <= 1'b0;
            r_addr_r  <= ADDR_W'(1'b0);
            sr_vld_r  <= {RD_LAT{1'b0}};
            sr_last_r <= {RD_LAT{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            addr_r    <= addr_nxt_s;
            rem_r     <= rem_nxt_s;
            r_en_r    <= issue_s;
            r_last_r  <= issue_last_s;
            if (issue_s) begin
                r_addr_r <= cur_addr_s;
            end else begin
                r_addr_r <= r_addr_r;
            end
            // Abort drops every outstanding read; its data is ignored on return.
            sr_vld_r  <= abort_i ? {RD_LAT{1'b0}} : sr_vld_nxt_s;
            sr_last_r <= sr_last_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    iob_regfile_scan_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_W + 1),
        .LVL_W (CRED_W)
    ) u_buf (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .flush_i  (abort_i),
        .push_i   (push_s),
        .din_i    ({sr_last_r[RD_LAT-1], bus.r_data_i}),
        .pop_i    (bus.ready_i),
        .dout_o   (head_s),
        .full_o   (full_s),
        .empty_o  (empty_s),
        .level_o  (level_s)
    );

    assign bus.r_en_o   = r_en_r;
    assign bus.r_addr_o = r_addr_r;
    assign bus.data_o   = head_s[DATA_W-1:0];
    assign bus.last_o   = head_s[DATA_W];
    assign bus.valid_o  = ~empty_s;
    assign busy_o       = busy_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_iob_regfile_scan_reader.sv
// Self-checking bench for iob_regfile_scan_reader.
// Regfile model: entry k reads as 32'hA000_0000 + k, RD_LAT cycles after the request.
module tb_iob_regfile_scan_reader;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int BUF_DEPTH = 4;

    logic              clk;
    logic              arst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic              busy;
    logic              done;

    int checks;
    int failures;
    int outstanding;

    iob_regfile_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_regfile_scan_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .start_i      (start),
        .start_addr_i (start_addr),
        .count_i      (count),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile read model with fixed latency.
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic              pipe_vld  [RD_LAT];

    initial begin
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_addr[i] = '0;
            pipe_vld[i]  = 1'b0;
        end
    end

    always @(posedge clk) begin
        pipe_vld[0]  <= bus.r_en_o;
        pipe_addr[0] <= bus.r_addr_o;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    assign bus.r_data_i = pipe_vld[RD_LAT-1] ? {28'hA000000, pipe_addr[RD_LAT-1]} : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Words requested but not yet taken by the sink, counted from the bench side.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            outstanding <= 0;
        end else if (abort) begin
            outstanding <= 0;
        end else begin
            outstanding <= outstanding + int'(bus.r_en_o) - int'(bus.valid_o & bus.ready_i);
        end
    end

    // Buffer occupancy plus in-flight reads must never exceed BUF_DEPTH.
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            check("credit_bound", ((outstanding + int'(bus.r_en_o)) <= BUF_DEPTH) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    typedef struct {
        logic [3:0]  sa;
        logic [4:0]  cnt;
        logic [3:0]  pat;
        bit          dup;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [8];

    // One complete scan: start, collect words under a ready pattern, check order,
    // last flag, word count, the done pulse and the idle state afterwards.
    task automatic run_scan(input string tag, input logic [3:0] sa, input logic [4:0] cnt,
                            input logic [3:0] pat, input bit dup, input logic [31:0] exp_last);
        int          got;
        int          dones;
        int          cyc;
        logic [3:0]  ea;
        logic [31:0] last_data;
        got = 0; dones = 0; cyc = 0; last_data = 32'h0;
        start = 1'b1; start_addr = sa; count = cnt; bus.ready_i = pat[0];
        while ((got < int'(cnt)) && (cyc < 300)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (dup && (cyc == 1)) begin
                start = 1'b1; start_addr = sa + 4'd8; count = 5'd5;
            end
            if (done) dones++;
            bus.ready_i = pat[cyc % 4];
            if (bus.valid_o && bus.ready_i) begin
                ea = sa + got[3:0];
                check($sformatf("%s_word%0d", tag, got), bus.data_o, {28'hA000000, ea});
                check($sformatf("%s_last%0d", tag, got), {31'd0, bus.last_o}, (got == int'(cnt) - 1) ? 32'd1 : 32'd0);
                last_data = bus.data_o;
                got++;
            end
        end
        start = 1'b0;
        check({tag, "_count"}, got, {27'd0, cnt});
        check({tag, "_early_done"}, dones, 32'd0);
        check({tag, "_final_word"}, last_data, exp_last);
        @(negedge clk);
        bus.ready_i = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        check({tag, "_valid_off"}, {31'd0, bus.valid_o}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [10:0] ren_m, val_m, done_m, busy_m;
        logic [3:0]  a;
        int          got;
        int          ren_cnt;

        checks = 0; failures = 0;
        arst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start_addr = '0; count = '0; bus.ready_i = 1'b0;

        vecs[0] = '{4'd3,  5'd5,  4'b1111, 1'b0, 32'hA000_0007};
        vecs[1] = '{4'd14, 5'd4,  4'b1111, 1'b0, 32'hA000_0001};
        vecs[2] = '{4'd0,  5'd16, 4'b1111, 1'b0, 32'hA000_000F};
        vecs[3] = '{4'd5,  5'd8,  4'b1001, 1'b0, 32'hA000_000C};
        vecs[4] = '{4'd15, 5'd1,  4'b1111, 1'b0, 32'hA000_000F};
        vecs[5] = '{4'd10, 5'd16, 4'b0101, 1'b0, 32'hA000_0009};
        vecs[6] = '{4'd7,  5'd3,  4'b0001, 1'b0, 32'hA000_0009};
        vecs[7] = '{4'd4,  5'd3,  4'b1111, 1'b1, 32'hA000_0006};

        repeat (3) @(negedge clk);
        check("rst_r_en",   {31'd0, bus.r_en_o},  32'd0);
        check("rst_r_addr", {28'd0, bus.r_addr_o}, 32'd0);
        check("rst_valid",  {31'd0, bus.valid_o}, 32'd0);
        check("rst_last",   {31'd0, bus.last_o},  32'd0);
        check("rst_data",   bus.data_o,           32'd0);
        check("rst_busy",   {31'd0, busy},        32'd0);
        check("rst_done",   {31'd0, done},        32'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Exact cycle timing of a 5-word scan from address 3 with ready held high.
        ren_m  = 11'b00000111110;
        val_m  = 11'b00111110000;
        done_m = 11'b01000000000;
        busy_m = 11'b00111111110;
        start = 1'b1; start_addr = 4'd3; count = 5'd5; bus.ready_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("lat_r_en_c%0d", c),  {31'd0, bus.r_en_o},  {31'd0, ren_m[c]});
            a = (c <= 5) ? (4'd3 + 4'(c - 1)) : 4'd7;
            check($sformatf("lat_r_addr_c%0d", c), {28'd0, bus.r_addr_o}, {28'd0, a});
            check($sformatf("lat_valid_c%0d", c), {31'd0, bus.valid_o}, {31'd0, val_m[c]});
            if (val_m[c]) begin
                a = 4'd3 + 4'(c - 4);
                check($sformatf("lat_data_c%0d", c), bus.data_o, {28'hA000000, a});
                check($sformatf("lat_last_c%0d", c), {31'd0, bus.last_o}, (c == 8) ? 32'd1 : 32'd0);
            end
            check($sformatf("lat_done_c%0d", c),  {31'd0, done}, {31'd0, done_m[c]});
            check($sformatf("lat_busy_c%0d", c),  {31'd0, busy}, {31'd0, busy_m[c]});
        end
        bus.ready_i = 1'b0;
        @(negedge clk);

        // Table-driven scans.
        for (int v = 0; v < 8; v++) begin
            run_scan($sformatf("vec%0d", v), vecs[v].sa, vecs[v].cnt, vecs[v].pat, vecs[v].dup, vecs[v].exp_last);
        end

        // Empty scan: no read request, done pulses the next cycle, never busy.
        start = 1'b1; start_addr = 4'd2; count = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_r_en", {31'd0, bus.r_en_o}, 32'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("zero_done_pulse", {31'd0, done}, 32'd0);
        check("zero_r_en2", {31'd0, bus.r_en_o}, 32'd0);
        check("zero_valid", {31'd0, bus.valid_o}, 32'd0);

        // Abort after the second transfer, then restart immediately.
        start = 1'b1; start_addr = 4'd0; count = 5'd6; bus.ready_i = 1'b1;
        got = 0;
        for (int c = 0; (c < 50) && (got < 2); c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.valid_o && bus.ready_i) begin
                check($sformatf("abort_word%0d", got), bus.data_o, 32'hA000_0000 + 32'(got));
                got++;
            end
        end
        check("abort_pre_count", got, 32'd2);
        @(negedge clk);
        abort = 1'b1; bus.ready_i = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {31'd0, bus.valid_o}, 32'd0);
        check("abort_busy",  {31'd0, busy},        32'd0);
        check("abort_r_en",  {31'd0, bus.r_en_o},  32'd0);
        check("abort_done",  {31'd0, done},        32'd0);
        run_scan("restart", 4'd9, 5'd2, 4'b1111, 1'b0, 32'hA000_000A);

        // Hold ready low: issue stops at BUF_DEPTH words, then reset mid-scan.
        start = 1'b1; start_addr = 4'd1; count = 5'd10; bus.ready_i = 1'b0;
        ren_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.r_en_o) ren_cnt++;
        end
        check("stall_issue_count", ren_cnt, BUF_DEPTH);
        check("stall_valid", {31'd0, bus.valid_o}, 32'd1);
        check("stall_head", bus.data_o, 32'hA000_0001);
        #2;
        arst_n = 1'b0;
        #1;
        check("arst_r_en",   {31'd0, bus.r_en_o},   32'd0);
        check("arst_r_addr", {28'd0, bus.r_addr_o}, 32'd0);
        check("arst_valid",  {31'd0, bus.valid_o},  32'd0);
        check("arst_last",   {31'd0, bus.last_o},   32'd0);
        check("arst_data",   bus.data_o,            32'd0);
        check("arst_busy",   {31'd0, busy},         32'd0);
        check("arst_done",   {31'd0, done},         32'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        run_scan("after_rst", 4'd6, 5'd4, 4'b1111, 1'b0, 32'hA000_0009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
